// File: rtl/cpu_stack.sv
// -----------------------------------------------------------------------------
// cpu_stack -- parametrised LIFO for the cpu_execute parameter/return stacks.
//
// The pointer moves by a signed step (hold / +1 / -1) and an optional write
// lands at the post-move pointer, so push, pop and replace-TOS each take one
// cycle. The top entry is read combinationally from mem[sp]. A write appears
// on top in the cycle after the edge that performed it.
//
// Optional feature macro: CPU_STACK_GUARD_EN
//   defined   : a push while full or a pop while empty is blocked and sets a
//               sticky overflow/underflow flag. clr_err clears the flags.
//   undefined : sp wraps freely (circular stack), writes always happen,
//               count saturates, and the flags are tied to 0.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous active-low reset
//   delta      in   2        SP step: 00/10 hold, 01 +1 (push), 11 -1 (pop)
//   we         in   1        write wdata to mem[SP_next] at the edge
//   wdata      in   WIDTH    write data
//   clr_err    in   1        synchronous clear of overflow/underflow
//   top        out  WIDTH    mem[sp], combinational
//   sp         out  PTR_W    current stack pointer
//   count      out  PTR_W+1  occupancy, 0..DEPTH
//   empty      out  1        count == 0
//   full       out  1        count == DEPTH
//   overflow   out  1        sticky: push attempted while full
//   underflow  out  1        sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module cpu_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,  // power of two, >= 2
  parameter int PTR_W = $clog2(DEPTH)  // derived; do not override
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       delta,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] sp,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [1:0] {
    D_HOLD  = 2'b00,
    D_PUSH  = 2'b01,
    D_HOLD2 = 2'b10,
    D_POP   = 2'b11
  } delta_e;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, sp_step;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, is_empty, is_full;
  logic             block_push, block_pop, wr_en;
  delta_e           op;

  assign op       = delta_e'(delta);
  assign push     = (op == D_PUSH);
  assign pop      = (op == D_POP);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    sp_step = sp_q;
    unique case (op)
      D_PUSH:  sp_step = sp_q + PTR_W'(1);
      D_POP:   sp_step = sp_q - PTR_W'(1);
      default: sp_step = sp_q;  // 00 and 10 both hold
    endcase
  end

`ifdef CPU_STACK_GUARD_EN
  assign block_push = push & is_full;
  assign block_pop  = pop & is_empty;

  always_comb begin
    // A new error in the same cycle as clr_err wins, so the flag stays set.
    ovf_d = (ovf_q & ~clr_err) | block_push;
    unf_d = (unf_q & ~clr_err) | block_pop;
  end
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign block_push     = 1'b0;
  assign block_pop      = 1'b0;
  assign ovf_d          = 1'b0;
  assign unf_d          = 1'b0;
`endif

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    wr_en   = we & ~block_push;
    if (!(block_push || block_pop)) begin
      sp_d = sp_step;
    end
    if (push && !is_full) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (pop && !is_empty) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM/flops
  // without a reset tree. Gating on reset_n aborts a write whose edge
  // arrives while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      mem_q[sp_d] <= wdata;
    end
  end

  assign top       = mem_q[sp_q];
  assign sp        = sp_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_cpu_stack.sv
// -----------------------------------------------------------------------------
// tb_cpu_stack -- self-checking bench for cpu_stack.
// u16 : DEPTH=16. Driven from a vector table, then through underflow and
//       asynchronous reset corner cases.
// u4  : DEPTH=4. Driven through a hand-written wrap/overflow/underflow
//       sequence.
// Expectations follow the CPU_STACK_GUARD_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_cpu_stack;

`ifdef CPU_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic [1:0]  a_delta;
  logic        a_we, a_clr;
  logic [15:0] a_wdata, a_top;
  logic [3:0]  a_sp;
  logic [4:0]  a_count;
  logic        a_empty, a_full, a_ovf, a_unf;

  cpu_stack #(.WIDTH(16), .DEPTH(16)) u16 (
    .clk(clk), .reset_n(reset_n), .delta(a_delta), .we(a_we),
    .wdata(a_wdata), .clr_err(a_clr), .top(a_top), .sp(a_sp),
    .count(a_count), .empty(a_empty), .full(a_full),
    .overflow(a_ovf), .underflow(a_unf)
  );

  // DEPTH=4 instance
  logic [1:0]  b_delta;
  logic        b_we, b_clr;
  logic [15:0] b_wdata, b_top;
  logic [1:0]  b_sp;
  logic [2:0]  b_count;
  logic        b_empty, b_full, b_ovf, b_unf;

  cpu_stack #(.WIDTH(16), .DEPTH(4)) u4 (
    .clk(clk), .reset_n(reset_n), .delta(b_delta), .we(b_we),
    .wdata(b_wdata), .clr_err(b_clr), .top(b_top), .sp(b_sp),
    .count(b_count), .empty(b_empty), .full(b_full),
    .overflow(b_ovf), .underflow(b_unf)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Wait for the active edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] d, input logic w,
                         input logic [15:0] wd, input logic c);
    a_delta = d; a_we = w; a_wdata = wd; a_clr = c;
  endtask

  task automatic drive_b(input logic [1:0] d, input logic w,
                         input logic [15:0] wd, input logic c);
    b_delta = d; b_we = w; b_wdata = wd; b_clr = c;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  delta;
    logic        we;
    logic [15:0] wdata;
    logic [3:0]  exp_sp;
    logic [4:0]  exp_count;
    logic        chk_top;
    logic [15:0] exp_top;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"push1234",   2'b01, 1'b1, 16'h1234, 4'd1, 5'd1, 1'b1, 16'h1234, 1'b0};
    vecs[1] = '{"push5678",   2'b01, 1'b1, 16'h5678, 4'd2, 5'd2, 1'b1, 16'h5678, 1'b0};
    vecs[2] = '{"pop",        2'b11, 1'b0, 16'h0000, 4'd1, 5'd1, 1'b1, 16'h1234, 1'b0};
    vecs[3] = '{"hold00",     2'b00, 1'b0, 16'hffff, 4'd1, 5'd1, 1'b1, 16'h1234, 1'b0};
    vecs[4] = '{"hold10",     2'b10, 1'b0, 16'hffff, 4'd1, 5'd1, 1'b1, 16'h1234, 1'b0};
    vecs[5] = '{"replace",    2'b00, 1'b1, 16'h0abc, 4'd1, 5'd1, 1'b1, 16'h0abc, 1'b0};
    vecs[6] = '{"push_nowr",  2'b01, 1'b0, 16'hdead, 4'd2, 5'd2, 1'b1, 16'h5678, 1'b0};
    vecs[7] = '{"pop2",       2'b11, 1'b0, 16'h0000, 4'd1, 5'd1, 1'b1, 16'h0abc, 1'b0};
    vecs[8] = '{"pop_to_0",   2'b11, 1'b0, 16'h0000, 4'd0, 5'd0, 1'b0, 16'h0000, 1'b1};

    reset_n = 1'b0;
    drive_a(2'b00, 1'b0, 16'h0, 1'b0);
    drive_b(2'b00, 1'b0, 16'h0, 1'b0);
    step();
    step();

    // Reset state
    check("rst_sp",    32'(a_sp), 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_full",  32'(a_full), 32'd0);
    check("rst_ovf",   32'(a_ovf), 32'd0);
    check("rst_unf",   32'(a_unf), 32'd0);
    reset_n = 1'b1;

    // Table-driven basic operations on u16
    for (int i = 0; i < 9; i++) begin
      drive_a(vecs[i].delta, vecs[i].we, vecs[i].wdata, 1'b0);
      step();
      check({vecs[i].name, "_sp"},    32'(a_sp), 32'(vecs[i].exp_sp));
      check({vecs[i].name, "_count"}, 32'(a_count), 32'(vecs[i].exp_count));
      check({vecs[i].name, "_empty"}, 32'(a_empty), 32'(vecs[i].exp_empty));
      check({vecs[i].name, "_full"},  32'(a_full), 32'd0);
      if (vecs[i].chk_top) begin
        check({vecs[i].name, "_top"}, 32'(a_top), 32'(vecs[i].exp_top));
      end
    end

    // Pop on an empty u16
    drive_a(2'b11, 1'b0, 16'h0, 1'b0);
    step();
    check("pop_empty_sp",    32'(a_sp), GUARD ? 32'd0 : 32'd15);
    check("pop_empty_count", 32'(a_count), 32'd0);
    check("pop_empty_unf",   32'(a_unf), 32'(GUARD));

    // Push, then drop reset between edges: state clears with no clock edge.
    drive_a(2'b01, 1'b1, 16'h4321, 1'b0);
    step();
    check("pre_rst_count", 32'(a_count), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_sp",    32'(a_sp), 32'd0);
    check("async_rst_count", 32'(a_count), 32'd0);
    check("async_rst_unf",   32'(a_unf), 32'd0);
    check("async_rst_empty", 32'(a_empty), 32'd1);
    // A push edge while reset is held changes nothing.
    step();
    check("held_rst_sp", 32'(a_sp), 32'd0);
    drive_a(2'b00, 1'b0, 16'h0, 1'b0);
    reset_n = 1'b1;

    // u4: five pushes of 1..5
    for (int i = 1; i <= 5; i++) begin
      drive_b(2'b01, 1'b1, 16'(i), 1'b0);
      step();
    end
    check("d4_push5_sp",    32'(b_sp), GUARD ? 32'd0 : 32'd1);
    check("d4_push5_count", 32'(b_count), 32'd4);
    check("d4_push5_full",  32'(b_full), 32'd1);
    check("d4_push5_top",   32'(b_top), GUARD ? 32'd4 : 32'd5);
    check("d4_push5_ovf",   32'(b_ovf), 32'(GUARD));

    // clr_err alone
    drive_b(2'b00, 1'b0, 16'h0, 1'b1);
    step();
    check("d4_clr_ovf", 32'(b_ovf), 32'd0);
    check("d4_clr_sp",  32'(b_sp), GUARD ? 32'd0 : 32'd1);

    // Push while full together with clr_err: a new error wins.
    drive_b(2'b01, 1'b1, 16'h0009, 1'b1);
    step();
    check("d4_ovf_clr_ovf",   32'(b_ovf), 32'(GUARD));
    check("d4_ovf_clr_sp",    32'(b_sp), GUARD ? 32'd0 : 32'd2);
    check("d4_ovf_clr_top",   32'(b_top), GUARD ? 32'd4 : 32'd9);
    check("d4_ovf_clr_count", 32'(b_count), 32'd4);

    // Drain four entries.
    for (int i = 0; i < 4; i++) begin
      drive_b(2'b11, 1'b0, 16'h0, 1'b0);
      step();
    end
    check("d4_drain_sp",    32'(b_sp), GUARD ? 32'd0 : 32'd2);
    check("d4_drain_count", 32'(b_count), 32'd0);
    check("d4_drain_empty", 32'(b_empty), 32'd1);
    check("d4_drain_full",  32'(b_full), 32'd0);

    // Pop while empty
    drive_b(2'b11, 1'b0, 16'h0, 1'b0);
    step();
    check("d4_unf_sp",    32'(b_sp), GUARD ? 32'd0 : 32'd1);
    check("d4_unf_count", 32'(b_count), 32'd0);
    check("d4_unf_flag",  32'(b_unf), 32'(GUARD));

    // Pop while empty together with clr_err: the flag stays set.
    drive_b(2'b11, 1'b0, 16'h0, 1'b1);
    step();
    check("d4_unf_clr_flag", 32'(b_unf), 32'(GUARD));
    check("d4_unf_clr_sp",   32'(b_sp), 32'd0);

    // Replace on an empty stack raises no flag.
    drive_b(2'b00, 1'b1, 16'h00aa, 1'b1);
    step();
    drive_b(2'b00, 1'b1, 16'h00bb, 1'b0);
    step();
    check("d4_repl_empty_unf", 32'(b_unf), 32'd0);
    check("d4_repl_empty_top", 32'(b_top), 32'h00bb);
    check("d4_repl_empty_cnt", 32'(b_count), 32'd0);

    drive_b(2'b00, 1'b0, 16'h0, 1'b0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
